// File: rtl/pico_button_port.sv
// pico_button_port: KCPSM3 input-port responder for the eight board switches.
// Each input is synchronised and debounced. The block keeps a debounced level
// and a sticky rising-edge event register, returns either one on the in_port
// path, and raises an interrupt with the interrupt/interrupt_ack handshake.
module pico_button_port #(
  parameter int         DEBOUNCE_CYCLES = 250000,
  parameter int         CNT_W           = 18,
  parameter logic [7:0] PORT_LEVEL      = 8'hFE,
  parameter logic [7:0] PORT_EVENT      = 8'hFC,
  parameter bit         IRQ_EN          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sw_in,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       interrupt_ack,
  output logic [7:0] in_port_data,
  output logic       port_hit,
  output logic [7:0] sw_level,
  output logic       interrupt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  logic [7:0]       sync_p0;
  logic [7:0]       sync_p1;
  logic [CNT_W-1:0] cnt [8];
  logic [7:0]       lvl_prev;
  logic [7:0]       evt_set;
  logic [7:0]       clr_mask;
  logic [7:0]       ev_reg;
  logic             hit_level;
  logic             hit_event;
  state_t           state;
  state_t           state_nxt;

  // Selects the value returned on the port bus for the current address.
  function automatic logic [7:0] read_sel(input logic       sel_level,
                                          input logic       sel_event,
                                          input logic [7:0] level,
                                          input logic [7:0] events);
    logic [7:0] r;
    r = 8'h00;
    if (sel_level)
      r = level;
    else if (sel_event)
      r = events;
    return r;
  endfunction

  assign hit_level = (port_id == PORT_LEVEL);
  assign hit_event = (port_id == PORT_EVENT);

  // A rising edge is the debounced level now high while it was low last cycle.
  assign evt_set  = sw_level & ~lvl_prev;
  // Only bits already pending at the time of the read are cleared.
  assign clr_mask = (read_strobe && hit_event) ? ev_reg : 8'h00;

  // Two-flop synchroniser for the asynchronous switch inputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_p0 <= 8'h00;
      sync_p1 <= 8'h00;
    end else begin
      sync_p0 <= sw_in;
      sync_p1 <= sync_p0;
    end
  end

  // Per-bit debounce: the level flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sw_level <= 8'h00;
      for (int i = 0; i < 8; i++)
        cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (sync_p1[i] == sw_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          sw_level[i] <= ~sw_level[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // Sticky event register; a new set in the same cycle as a clear wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      lvl_prev <= 8'h00;
      ev_reg   <= 8'h00;
    end else begin
      lvl_prev <= sw_level;
      ev_reg   <= (ev_reg & ~clr_mask) | evt_set;
    end
  end

  // Registered read path, decoded every cycle so data is ready when INPUT samples it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      in_port_data <= 8'h00;
      port_hit     <= 1'b0;
    end else begin
      in_port_data <= read_sel(hit_level, hit_event, sw_level, ev_reg);
      port_hit     <= hit_level | hit_event;
    end
  end

  // Interrupt FSM state register.
  always_ff @(posedge clk) begin
    if (!rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Interrupt FSM next state: request on pending events, wait in SERVICE until they are read.
  always_comb begin
    state_nxt = state;
    if (!IRQ_EN) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (ev_reg != 8'h00) state_nxt = REQ;
        REQ:     if (interrupt_ack)   state_nxt = SERVICE;
        SERVICE: if (ev_reg == 8'h00) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Interrupt FSM output: the request is held only while waiting for the acknowledge.
  always_comb begin
    interrupt = 1'b0;
    if (state == REQ)
      interrupt = 1'b1;
  end

endmodule
